elevator_ctrl: RTL and testbench
================================

# elevator_ctrl

Parametrised single-car elevator controller: latches hall and car requests, schedules the car with direction-preserving (SCAN) logic, and runs move and door timers from a slow tick enable. It generalises the current 8-floor FSM and status wrapper to N floors and adds request buffering, lamp outputs and door open/close override. It sits between the board button inputs and the floor/countdown/status displays.

## Interface
- FLOORS, 8, number of floors (≥2); floors numbered 0..FLOORS-1
- FLOOR_W, 3, width of floor output; 2^FLOOR_W ≥ FLOORS
- CNT_W, 3, width of countdown
- MOVE_TICKS, 2, ticks to travel one floor (1..2^CNT_W-1)
- DOOR_TICKS, 3, ticks door stays open (1..2^CNT_W-1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-clk-wide timer enable (slow count clock, synchronous to clk)
- upcall  in  FLOORS  hall up requests, level, bit i = floor i
- downcall  in  FLOORS  hall down requests
- car_btn  in  FLOORS  in-car floor buttons
- door_open  in  1  door-open button
- door_close  in  1  door-close button
- floor  out  FLOOR_W  current floor
- countdown  out  CNT_W  remaining ticks of current move/door phase
- state  out  2  0 IDLE, 1 UP, 2 DOWN, 3 DOOR
- dir_up  out  1  direction memory (1 = up)
- up_lamp, down_lamp, car_lamp  out  FLOORS  latched request vectors

## Operation
- Reset: floor=0, state=IDLE, countdown=0, dir_up=1, all lamps 0. Applies mid-move or mid-door; all pending requests are dropped.
- Latching: every clk, any input bit high sets its lamp bit. upcall[FLOORS-1] and downcall[0] are masked (never latch). A request for the current floor while state=DOOR is not latched; it reloads countdown to DOOR_TICKS instead.
- "Above"/"below" = any lamp bit (any vector) at floor strictly greater/less than floor. "Here" = any lamp bit at floor.
- IDLE (no tick needed): if here → DOOR, load DOOR_TICKS, clear all three lamps at floor. Else if above and below both pending → move toward dir_up. Else above → UP; below → DOWN. Entering UP/DOWN loads MOVE_TICKS and sets dir_up accordingly. With no requests, remain in IDLE.
- UP/DOWN: on tick, if countdown>1 decrement; if countdown==1, floor ±1 and evaluate the new floor f:
  - UP stops if car_lamp[f] | up_lamp[f] | (down_lamp[f] & no requests above f). DOWN is symmetric.
  - On stop: DOOR, load DOOR_TICKS, clear car_lamp[f] and the hall lamp in the travel direction. If the stop is due only to the opposite hall lamp, clear that lamp and flip dir_up.
  - Otherwise reload MOVE_TICKS and continue.
  - Floor never passes 0 or FLOORS-1: UP is never entered with nothing above.
- DOOR: on tick, countdown>1 decrement; countdown==1 → exit. door_open reloads DOOR_TICKS. door_close forces exit on the next clk edge regardless of tick. If open and close are asserted together, open wins.
- Door exit: requests ahead in dir_up → continue (UP/DOWN, MOVE_TICKS). Else requests behind → reverse dir_up and move. Else → IDLE, countdown=0.
- door_open in IDLE → DOOR at current floor with DOOR_TICKS.

## Timing
- All outputs are registered.
- Input high in cycle n → lamp visible in cycle n+1.
- In IDLE, the state change is visible at n+2.
- Lamps clear in the same cycle that state becomes DOOR.
- A tick arriving together with a state-entry load is consumed by the load; it does not decrement.
- Door dwell is exactly DOOR_TICKS ticks. Floor travel is exactly MOVE_TICKS ticks.
- Simultaneous set and clear of the same lamp bit: clear wins on DOOR-entry cycles only if the requesting input is low. An input still held re-latches, except when it is for the current floor in DOOR, which is handled by the reload rule.

## Test plan
Defaults apply; tick asserted every clk unless stated.
- Reset: rst high for 2 clk with random buttons → floor 0, state 0, countdown 0, dir_up 1, all lamps 0. Assert rst during UP at floor 2 → same values on the next clk.
- Single call: car_btn[3] pulse at floor 0 → car_lamp[3] set; UP; floor increments every 2 ticks; floor=3 with DOOR, countdown 3, car_lamp[3]=0. After 3 more ticks → IDLE.
- SCAN pass-through: at floor 0, set car_btn[5] and downcall[2] → no stop at 2 going up; stop at 5; reverse, DOWN; stop at 2 with down_lamp[2] cleared; then IDLE.
- Door override: in DOOR at countdown 1, pulse door_open → countdown 3. Pulse door_close with tick held low → exit on the next clk. Assert both together → countdown reloads, no exit.
- Masking and here-request: upcall[7] and downcall[0] pulses → lamps stay 0, state IDLE. upcall[0] pulse while idle at floor 0 → DOOR two clk later, up_lamp[0] cleared.
- Reversal at top: car_btn[7] from floor 6 → arrive at 7; exit DOOR to IDLE. Floor never exceeds 7.

Source files
------------

// File: rtl/elevator_ctrl.sv
// Single-car SCAN elevator controller: latches hall/car requests into lamp
// registers and steps the car between floors on a slow tick enable.
module elevator_ctrl #(
    parameter int FLOORS     = 8,
    parameter int FLOOR_W    = 3,
    parameter int CNT_W      = 3,
    parameter int MOVE_TICKS = 2,
    parameter int DOOR_TICKS = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [FLOORS-1:0]  upcall,
    input  logic [FLOORS-1:0]  downcall,
    input  logic [FLOORS-1:0]  car_btn,
    input  logic               door_open,
    input  logic               door_close,
    output logic [FLOOR_W-1:0] floor,
    output logic [CNT_W-1:0]   countdown,
    output logic [1:0]         state,
    output logic               dir_up,
    output logic [FLOORS-1:0]  up_lamp,
    output logic [FLOORS-1:0]  down_lamp,
    output logic [FLOORS-1:0]  car_lamp
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_DOOR = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0]   MOVE_LD  = CNT_W'(MOVE_TICKS);
    localparam logic [CNT_W-1:0]   DOOR_LD  = CNT_W'(DOOR_TICKS);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [FLOOR_W-1:0] TOP_FLR  = FLOOR_W'(FLOORS - 1);
    localparam logic [FLOOR_W-1:0] FLR_ONE  = FLOOR_W'(1);
    // No up call from the top floor, no down call from the bottom floor.
    localparam logic [FLOORS-1:0]  UP_MASK  = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0]  DN_MASK  = {{(FLOORS-1){1'b1}}, 1'b0};

    function automatic logic [FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
        return {{(FLOORS-1){1'b0}}, 1'b1} << f;
    endfunction

    function automatic logic [FLOORS-1:0] gt_mask(input logic [FLOOR_W-1:0] f);
        return {FLOORS{1'b1}} << (32'(f) + 32'd1);
    endfunction

    function automatic logic [FLOORS-1:0] lt_mask(input logic [FLOOR_W-1:0] f);
        return ~({FLOORS{1'b1}} << 32'(f));
    endfunction

    state_e             state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic [FLOORS-1:0]  up_q, up_d, dn_q, dn_d, car_q, car_d;

    logic [FLOORS-1:0]  clr_up, clr_dn, clr_car;
    logic [FLOORS-1:0]  set_up, set_dn, set_car, req_in;
    logic [FLOORS-1:0]  any_q, cur_oh, nf_oh, set_block;
    logic               above_cur, below_cur, here_cur, here_req;
    logic [FLOOR_W-1:0] nf;
    logic               ahead_nf, stop_dir, stop_opp, at_end;
    state_e             ex_state;
    logic               ex_dir;
    logic [CNT_W-1:0]   ex_cnt;

    // Request bookkeeping and the decisions shared by several states
    always_comb begin
        any_q     = up_q | dn_q | car_q;
        cur_oh    = onehot(floor_q);
        above_cur = |(any_q & gt_mask(floor_q));
        below_cur = |(any_q & lt_mask(floor_q));
        here_cur  = |(any_q & cur_oh);

        req_in    = (upcall & UP_MASK) | (downcall & DN_MASK) | car_btn;
        here_req  = (state_q == S_DOOR) && (|(req_in & cur_oh));
        set_block = (state_q == S_DOOR) ? cur_oh : '0;
        set_up    = upcall & UP_MASK & ~set_block;
        set_dn    = downcall & DN_MASK & ~set_block;
        set_car   = car_btn & ~set_block;

        nf    = (state_q == S_DOWN) ? (floor_q - FLR_ONE) : (floor_q + FLR_ONE);
        nf_oh = onehot(nf);
        if (state_q == S_DOWN) begin
            ahead_nf = |(any_q & lt_mask(nf));
            stop_dir = |((car_q | dn_q) & nf_oh);
            stop_opp = (|(up_q & nf_oh)) && !ahead_nf;
            at_end   = (nf == '0);
        end else begin
            ahead_nf = |(any_q & gt_mask(nf));
            stop_dir = |((car_q | up_q) & nf_oh);
            stop_opp = (|(dn_q & nf_oh)) && !ahead_nf;
            at_end   = (nf == TOP_FLR);
        end

        // Leaving the door: keep going, else turn around, else park.
        ex_state = S_IDLE;
        ex_dir   = dir_q;
        ex_cnt   = '0;
        if (dir_q ? above_cur : below_cur) begin
            ex_state = dir_q ? S_UP : S_DOWN;
            ex_cnt   = MOVE_LD;
        end else if (dir_q ? below_cur : above_cur) begin
            ex_state = dir_q ? S_DOWN : S_UP;
            ex_dir   = !dir_q;
            ex_cnt   = MOVE_LD;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            floor_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b1;
            up_q    <= '0;
            dn_q    <= '0;
            car_q   <= '0;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            car_q   <= car_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        clr_up  = '0;
        clr_dn  = '0;
        clr_car = '0;

        case (state_q)
            S_IDLE: begin
                if (here_cur || door_open) begin
                    state_d = S_DOOR;
                    cnt_d   = DOOR_LD;
                    clr_up  = cur_oh;
                    clr_dn  = cur_oh;
                    clr_car = cur_oh;
                end else if (above_cur && below_cur) begin
                    state_d = dir_q ? S_UP : S_DOWN;
                    cnt_d   = MOVE_LD;
                end else if (above_cur) begin
                    state_d = S_UP;
                    cnt_d   = MOVE_LD;
                    dir_d   = 1'b1;
                end else if (below_cur) begin
                    state_d = S_DOWN;
                    cnt_d   = MOVE_LD;
                    dir_d   = 1'b0;
                end
            end

            S_UP, S_DOWN: begin
                if (tick) begin
                    if (cnt_q > CNT_ONE) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        floor_d = nf;
                        if (stop_dir || stop_opp || at_end) begin
                            state_d = S_DOOR;
                            cnt_d   = DOOR_LD;
                            clr_car = nf_oh;
                            if (state_q == S_UP) clr_up = nf_oh;
                            else                 clr_dn = nf_oh;
                            // Stopping only for the opposite hall call turns the car round.
                            if (!stop_dir && stop_opp) begin
                                if (state_q == S_UP) clr_dn = nf_oh;
                                else                 clr_up = nf_oh;
                                dir_d = !dir_q;
                            end
                        end else begin
                            cnt_d = MOVE_LD;
                        end
                    end
                end
            end

            default: begin
                if (door_open || here_req) begin
                    cnt_d = DOOR_LD;
                end else if (door_close || (tick && cnt_q <= CNT_ONE)) begin
                    state_d = ex_state;
                    dir_d   = ex_dir;
                    cnt_d   = ex_cnt;
                end else if (tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
        endcase

        up_d  = (up_q  & ~clr_up)  | set_up;
        dn_d  = (dn_q  & ~clr_dn)  | set_dn;
        car_d = (car_q & ~clr_car) | set_car;
    end

    // Outputs straight from registers
    always_comb begin
        floor     = floor_q;
        countdown = cnt_q;
        state     = state_q;
        dir_up    = dir_q;
        up_lamp   = up_q;
        down_lamp = dn_q;
        car_lamp  = car_q;
    end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl with default parameters (8 floors,
// 2 ticks per floor, 3 ticks door dwell).
module tb_elevator_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [7:0] upcall, downcall, car_btn;
    logic       door_open, door_close;
    logic [2:0] floor;
    logic [2:0] countdown;
    logic [1:0] state;
    logic       dir_up;
    logic [7:0] up_lamp, down_lamp, car_lamp;

    int checks = 0;
    int errors = 0;

    elevator_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .upcall     (upcall),
        .downcall   (downcall),
        .car_btn    (car_btn),
        .door_open  (door_open),
        .door_close (door_close),
        .floor      (floor),
        .countdown  (countdown),
        .state      (state),
        .dir_up     (dir_up),
        .up_lamp    (up_lamp),
        .down_lamp  (down_lamp),
        .car_lamp   (car_lamp)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input logic [1:0] s, input logic [2:0] f,
                           input logic [2:0] c);
        chk({tag, "_state"}, 32'(state), 32'(s));
        chk({tag, "_floor"}, 32'(floor), 32'(f));
        chk({tag, "_cnt"},   32'(countdown), 32'(c));
    endtask

    initial begin
        rst = 1'b1; tick = 1'b1;
        door_open = 1'b0; door_close = 1'b0;
        upcall   = 8'($urandom);
        downcall = 8'($urandom);
        car_btn  = 8'($urandom);
        step(2);
        chk_pos("rst", 2'd0, 3'd0, 3'd0);
        chk("rst_dir", 32'(dir_up), 32'd1);
        chk("rst_lamps", 32'({up_lamp, down_lamp, car_lamp}), 32'd0);
        upcall = '0; downcall = '0; car_btn = '0; rst = 1'b0;
        step(1);
        chk_pos("post_rst", 2'd0, 3'd0, 3'd0);

        // Single call to floor 3
        car_btn = 8'h08;
        step(1);
        car_btn = '0;
        chk("sc_lamp", 32'(car_lamp), 32'h08);
        chk("sc_still_idle", 32'(state), 32'd0);
        step(1);
        chk_pos("sc_up", 2'd1, 3'd0, 3'd2);
        step(1);
        chk_pos("sc_cnt1", 2'd1, 3'd0, 3'd1);
        step(1);
        chk_pos("sc_f1", 2'd1, 3'd1, 3'd2);
        step(4);
        chk_pos("sc_arrive", 2'd3, 3'd3, 3'd3);
        chk("sc_lamp_clr", 32'(car_lamp), 32'h00);
        step(2);
        chk_pos("sc_door1", 2'd3, 3'd3, 3'd1);
        step(1);
        chk_pos("sc_idle", 2'd0, 3'd3, 3'd0);

        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_pos("rst2", 2'd0, 3'd0, 3'd0);

        // SCAN pass-through: car to 5, down call at 2
        car_btn = 8'h20; downcall = 8'h04;
        step(1);
        car_btn = '0; downcall = '0;
        chk("scan_car", 32'(car_lamp), 32'h20);
        chk("scan_dn", 32'(down_lamp), 32'h04);
        step(1);
        chk_pos("scan_up", 2'd1, 3'd0, 3'd2);
        step(4);
        chk_pos("scan_pass2", 2'd1, 3'd2, 3'd2);
        chk("scan_dn_kept", 32'(down_lamp), 32'h04);
        step(6);
        chk_pos("scan_at5", 2'd3, 3'd5, 3'd3);
        chk("scan_car_clr", 32'(car_lamp), 32'h00);
        step(3);
        chk_pos("scan_rev", 2'd2, 3'd5, 3'd2);
        chk("scan_dir0", 32'(dir_up), 32'd0);
        step(6);
        chk_pos("scan_at2", 2'd3, 3'd2, 3'd3);
        chk("scan_dn_clr", 32'(down_lamp), 32'h00);
        step(3);
        chk_pos("scan_idle", 2'd0, 3'd2, 3'd0);

        // Door overrides at floor 2
        door_open = 1'b1;
        step(1);
        door_open = 1'b0;
        chk_pos("do_open", 2'd3, 3'd2, 3'd3);
        step(2);
        chk("do_cnt1", 32'(countdown), 32'd1);
        door_open = 1'b1;
        step(1);
        door_open = 1'b0;
        chk_pos("do_reload", 2'd3, 3'd2, 3'd3);
        tick = 1'b0; door_close = 1'b1;
        step(1);
        door_close = 1'b0;
        chk_pos("do_close", 2'd0, 3'd2, 3'd0);
        door_open = 1'b1;
        step(1);
        door_open = 1'b0;
        step(1);
        chk_pos("do_notick", 2'd3, 3'd2, 3'd3);
        tick = 1'b1;
        step(1);
        chk("do_tick", 32'(countdown), 32'd2);
        door_open = 1'b1; door_close = 1'b1;
        step(1);
        door_open = 1'b0; door_close = 1'b0;
        chk_pos("do_both", 2'd3, 3'd2, 3'd3);
        step(3);
        chk_pos("do_exit", 2'd0, 3'd2, 3'd0);

        // Masked hall calls and a here-request
        upcall = 8'h80; downcall = 8'h01;
        step(1);
        upcall = '0; downcall = '0;
        chk("mask_lamps", 32'({up_lamp, down_lamp}), 32'd0);
        step(1);
        chk("mask_idle", 32'(state), 32'd0);
        upcall = 8'h04;
        step(1);
        upcall = '0;
        chk("here_lamp", 32'(up_lamp), 32'h04);
        chk("here_idle", 32'(state), 32'd0);
        step(1);
        chk_pos("here_door", 2'd3, 3'd2, 3'd3);
        chk("here_clr", 32'(up_lamp), 32'h00);
        step(1);
        car_btn = 8'h04;
        step(1);
        car_btn = '0;
        chk_pos("here_reload", 2'd3, 3'd2, 3'd3);
        chk("here_nolatch", 32'(car_lamp), 32'h00);
        step(3);
        chk_pos("here_exit", 2'd0, 3'd2, 3'd0);

        // Reset while moving up from floor 2
        car_btn = 8'h40;
        step(1);
        car_btn = '0;
        step(1);
        chk_pos("mrst_up", 2'd1, 3'd2, 3'd2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_pos("mrst", 2'd0, 3'd0, 3'd0);
        chk("mrst_dir", 32'(dir_up), 32'd1);
        chk("mrst_lamps", 32'({up_lamp, down_lamp, car_lamp}), 32'd0);

        // Up to 6, then to the top floor
        car_btn = 8'h40;
        step(1);
        car_btn = '0;
        step(13);
        chk_pos("top_at6", 2'd3, 3'd6, 3'd3);
        step(3);
        chk_pos("top_idle6", 2'd0, 3'd6, 3'd0);
        car_btn = 8'h80;
        step(2);
        car_btn = '0;
        step(2);
        chk_pos("top_at7", 2'd3, 3'd7, 3'd3);
        step(3);
        chk_pos("top_idle7", 2'd0, 3'd7, 3'd0);
        chk("top_lamps", 32'({up_lamp, down_lamp, car_lamp}), 32'd0);

        // Down to an up hall call with nothing below: turn round there
        upcall = 8'h08;
        step(1);
        upcall = '0;
        step(1);
        chk_pos("opp_down", 2'd2, 3'd7, 3'd2);
        chk("opp_dir0", 32'(dir_up), 32'd0);
        step(8);
        chk_pos("opp_at3", 2'd3, 3'd3, 3'd3);
        chk("opp_dir1", 32'(dir_up), 32'd1);
        chk("opp_clr", 32'(up_lamp), 32'h00);
        step(3);
        chk_pos("opp_idle", 2'd0, 3'd3, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
